// File: rtl/uart_pkg.sv
// uart_pkg: tx FSM state enum, cfg_dbits data-length encodings and length helpers
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;
  function automatic logic [7:0] dbits_mask(input logic [1:0] d);
    return d == DBITS_5 ? 8'h1f : d == DBITS_6 ? 8'h3f : d == DBITS_7 ? 8'h7f : 8'hff;
  endfunction
  function automatic logic [2:0] dbits_last(input logic [1:0] d);
    return 3'd4 + {1'b0, d};
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8-bit sync FIFO; wr_en/wr_data push, rd_en pops rd_data (show-ahead), flush clears, count/empty/full status
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       PRESET,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic                       rd_en,
  output logic [7:0]                 rd_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop;
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
  assign count = count_q;
  assign rd_data = mem[rd_ptr_q];
  always_comb begin
    push = wr_en && !full;
    pop = rd_en && !empty;
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clock) begin
    if (PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clock) if (push) mem[wr_ptr_q] <= wr_data;
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmitter; wr_* feed the TX FIFO, cfg_* frame format latched per character, nCTS gates pops, TXD serial out with busy/done/FIFO status
import uart_pkg::*;
module uart_tx_engine #(
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic                       clock,
  input  logic                       PRESET,
  input  logic                       wr_valid,
  input  logic [7:0]                 wr_data,
  output logic                       wr_ready,
  input  logic                       tx_flush,
  input  logic [1:0]                 cfg_dbits,
  input  logic                       cfg_par_en,
  input  logic                       cfg_par_odd,
  input  logic                       cfg_stop2,
  input  logic [DIV_W-1:0]           cfg_div,
  input  logic                       cfg_cts_en,
  input  logic                       nCTS,
  output logic                       TXD,
  output logic                       tx_busy,
  output logic                       tx_fifo_empty,
  output logic                       tx_fifo_full,
  output logic [$clog2(DEPTH+1)-1:0] tx_fifo_count,
  output logic                       tx_done
);
  tx_state_e state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [7:0] sh_q, sh_d, fifo_data;
  logic [2:0] idx_q, idx_d, last_q, last_d;
  logic par_q, par_d, par_en_q, par_en_d, stop2_q, stop2_d, stop_idx_q, stop_idx_d;
  logic txd_q, txd_d, busy_q, busy_d, done_q, done_d, pop;
  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock(clock), .PRESET(PRESET), .wr_en(wr_valid), .wr_data(wr_data), .rd_en(pop),
    .rd_data(fifo_data), .flush(tx_flush), .count(tx_fifo_count), .empty(tx_fifo_empty), .full(tx_fifo_full)
  );
  assign wr_ready = !tx_fifo_full;
  assign TXD = txd_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
  always_comb begin
    pop = state_q == IDLE && !tx_fifo_empty && (!cfg_cts_en || !nCTS);
    state_d = state_q;
    div_d = div_q;
    sh_d = sh_q;
    idx_d = idx_q;
    last_d = last_q;
    par_d = par_q;
    par_en_d = par_en_q;
    stop2_d = stop2_q;
    stop_idx_d = stop_idx_q;
    txd_d = txd_q;
    cnt_d = cnt_q != '0 ? cnt_q - DIV_W'(1) : div_q - DIV_W'(1);
    if (state_q == IDLE) begin
      cnt_d = '0;
      txd_d = 1'b1;
      if (pop) begin
        state_d = START;
        txd_d = 1'b0;
        div_d = cfg_div == '0 ? DIV_W'(1) : cfg_div;
        cnt_d = div_d - DIV_W'(1);
        sh_d = fifo_data & dbits_mask(cfg_dbits);
        last_d = dbits_last(cfg_dbits);
        par_d = ^sh_d ^ cfg_par_odd;
        par_en_d = cfg_par_en;
        stop2_d = cfg_stop2;
        stop_idx_d = 1'b0;
        idx_d = '0;
      end
    end else if (cnt_q == '0) begin
      // shift register always holds the next data bit in bit 0
      unique case (state_q)
        START: begin
          state_d = DATA;
          txd_d = sh_q[0];
          sh_d = sh_q >> 1;
        end
        DATA: begin
          if (idx_q == last_q) begin
            state_d = par_en_q ? PARITY : STOP;
            txd_d = par_en_q ? par_q : 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            txd_d = sh_q[0];
            sh_d = sh_q >> 1;
          end
        end
        PARITY: begin
          state_d = STOP;
          txd_d = 1'b1;
        end
        STOP: begin
          stop_idx_d = stop2_q && !stop_idx_q;
          state_d = stop2_q && !stop_idx_q ? STOP : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = state_d != IDLE;
    done_d = state_d == STOP && cnt_d == '0 && (!stop2_d || stop_idx_d);
  end
  always_ff @(posedge clock) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q <= '0;
      div_q <= DIV_W'(1);
      sh_q <= '0;
      idx_q <= '0;
      last_q <= '0;
      par_q <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q <= 1'b0;
      stop_idx_q <= 1'b0;
      txd_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      sh_q <= sh_d;
      idx_q <= idx_d;
      last_q <= last_d;
      par_q <= par_d;
      par_en_q <= par_en_d;
      stop2_q <= stop2_d;
      stop_idx_q <= stop_idx_d;
      txd_q <= txd_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule
